dcache: RTL and testbench

Direct-mapped, write-back, write-allocate data cache sitting between the CPU's byte-wide data port and the word-wide (4-byte block) data memory. It is the responder for the CPU's READ/WRITE/ADDRESS/WRITEDATA requests, stalling the CPU through BUSYWAIT on misses. It is the initiator toward data memory through MEM_READ/MEM_WRITE with MEM_BUSYWAIT handshake. Geometry: 8 lines × 4 bytes; ADDRESS = {tag[7:5], index[4:2], offset[1:0]}.

---
 rtl/dcache.sv | 117 +++++++++++
 tb/tb_dcache.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache.sv
// Direct-mapped write-back / write-allocate data cache: 8 lines x 4 bytes,
// byte-wide CPU port, word-wide memory port.
//
// state     | meaning
// IDLE      | serving hits; a miss picks WRITEBACK (dirty victim) or FETCH
// WRITEBACK | writing the dirty victim block to memory
// FETCH     | reading the requested block from memory into the line
module dcache (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_t;

  state_t      state, state_nxt;
  logic [7:0]  valid, dirty;
  logic [2:0]  tags [8];
  logic [31:0] data [8];
  logic        wr_ack;

  logic [2:0]  tag_in, index;
  logic [1:0]  offset;
  logic [4:0]  bit_sel;
  logic [31:0] blk;
  logic        hit, req;

  assign tag_in  = ADDRESS[7:5];
  assign index   = ADDRESS[4:2];
  assign offset  = ADDRESS[1:0];
  assign bit_sel = {offset, 3'b000};
  assign blk     = data[index];
  assign hit     = valid[index] && (tags[index] == tag_in);
  assign req     = READ || WRITE;

  // a store on a hit stalls for one edge; wr_ack releases the CPU afterwards
  assign BUSYWAIT = req && !RESET && !((state == IDLE) && hit && (!WRITE || wr_ack));
  assign READDATA = ((state == IDLE) && hit && READ && !WRITE && !RESET) ? blk[bit_sel +: 8] : 8'h00;

  always_comb begin
    state_nxt     = state;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = 6'h00;
    MEM_WRITEDATA = 32'h0;
    case (state)
      IDLE: begin
        if (req && !hit)
          state_nxt = (valid[index] && dirty[index]) ? WRITEBACK : FETCH;
      end
      WRITEBACK: begin
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {tags[index], index};
        MEM_WRITEDATA = blk;
        if (!MEM_BUSYWAIT)
          state_nxt = FETCH;
      end
      FETCH: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {tag_in, index};
        if (!MEM_BUSYWAIT)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= IDLE;
      valid  <= 8'h00;
      dirty  <= 8'h00;
      wr_ack <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        tags[i] <= 3'h0;
        data[i] <= 32'h0;
      end
    end else begin
      state  <= state_nxt;
      wr_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (WRITE && hit && !wr_ack) begin
            data[index][bit_sel +: 8] <= WRITEDATA;
            dirty[index]              <= 1'b1;
            wr_ack                    <= 1'b1;
          end
        end
        WRITEBACK: begin
          if (!MEM_BUSYWAIT)
            dirty[index] <= 1'b0;
        end
        FETCH: begin
          if (!MEM_BUSYWAIT) begin
            data[index]  <= MEM_READDATA;
            tags[index]  <= tag_in;
            valid[index] <= 1'b1;
            dirty[index] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache.sv
// Directed testbench for dcache with a fixed-latency block memory model.
module tb_dcache;

  logic        CLK = 1'b0;
  logic        RESET, READ, WRITE;
  logic [7:0]  ADDRESS, WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT, MEM_READ, MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  int checks   = 0;
  int failures = 0;

  localparam int MEM_LAT = 5;
  logic [3:0] mem_cnt;

  dcache dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
    .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  // memory: busy for MEM_LAT edges after a request appears, then completes
  assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mem_cnt < MEM_LAT);

  always_comb begin
    case (MEM_ADDRESS)
      6'h05:   MEM_READDATA = 32'hDDCCBBAA;
      6'h2D:   MEM_READDATA = 32'h44332211;
      6'h02:   MEM_READDATA = 32'h0D0C0B0A;
      default: MEM_READDATA = 32'hEEEEEEEE;
    endcase
  end

  always @(posedge CLK or posedge RESET) begin
    if (RESET) mem_cnt <= 4'd0;
    else if (!(MEM_READ || MEM_WRITE) || !MEM_BUSYWAIT) mem_cnt <= 4'd0;
    else mem_cnt <= mem_cnt + 4'd1;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_not_busy(input int bound, output int n);
    n = 0;
    while (BUSYWAIT !== 1'b0 && n < bound) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'h00; WRITEDATA = 8'h00;
    #3;
    checks++;
    if ({READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA} !== 49'h0) begin
      failures++;
      $display("FAIL reset_outputs: got rd=%h bw=%b mr=%b mw=%b ma=%h mwd=%h expected all zero",
               READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA);
    end
    READ = 1'b1; ADDRESS = 8'h14;
    #1;
    checks++;
    if (BUSYWAIT !== 1'b0) begin failures++; $display("FAIL reset_busywait: got %b expected 0", BUSYWAIT); end
    READ = 1'b0;
    step();
    RESET = 1'b0;
    step();
  endtask

  task automatic test_read_miss();
    int n;
    READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h14;
    #1;
    checks++;
    if (BUSYWAIT !== 1'b1 || READDATA !== 8'h00 || MEM_READ !== 1'b0) begin
      failures++;
      $display("FAIL miss_idle: got bw=%b rd=%h mr=%b expected bw=1 rd=00 mr=0", BUSYWAIT, READDATA, MEM_READ);
    end
    step();
    checks++;
    if (MEM_READ !== 1'b1 || MEM_WRITE !== 1'b0 || MEM_ADDRESS !== 6'h05 || BUSYWAIT !== 1'b1) begin
      failures++;
      $display("FAIL miss_fetch: got mr=%b mw=%b ma=%h bw=%b expected mr=1 mw=0 ma=05 bw=1",
               MEM_READ, MEM_WRITE, MEM_ADDRESS, BUSYWAIT);
    end
    wait_not_busy(20, n);
    checks++;
    if (n !== 6) begin failures++; $display("FAIL miss_latency: got %0d cycles expected 6", n); end
    checks++;
    if (READDATA !== 8'hAA || MEM_READ !== 1'b0) begin
      failures++;
      $display("FAIL miss_data: got rd=%h mr=%b expected rd=aa mr=0", READDATA, MEM_READ);
    end
  endtask

  task automatic test_read_hits();
    logic [7:0] exp [3];
    exp = '{8'hBB, 8'hCC, 8'hDD};
    for (int i = 0; i < 3; i++) begin
      ADDRESS = 8'h15 + 8'(i);
      #1;
      checks++;
      if (READDATA !== exp[i] || BUSYWAIT !== 1'b0 || MEM_READ !== 1'b0) begin
        failures++;
        $display("FAIL read_hit_%0d: got rd=%h bw=%b mr=%b expected rd=%h bw=0 mr=0",
                 i, READDATA, BUSYWAIT, MEM_READ, exp[i]);
      end
    end
    step();
  endtask

  task automatic test_back_to_back();
    READ = 1'b0; WRITE = 1'b1; ADDRESS = 8'h16; WRITEDATA = 8'h5A;
    #1;
    checks++;
    if (BUSYWAIT !== 1'b1) begin failures++; $display("FAIL wr_hit_stall: got %b expected 1", BUSYWAIT); end
    step();
    checks++;
    if (BUSYWAIT !== 1'b0) begin failures++; $display("FAIL wr_hit_ack: got %b expected 0", BUSYWAIT); end
    step();
    ADDRESS = 8'h17; WRITEDATA = 8'hDD;
    #1;
    checks++;
    if (BUSYWAIT !== 1'b1) begin failures++; $display("FAIL wr_ack_clear: got %b expected 1", BUSYWAIT); end
    step();
    checks++;
    if (BUSYWAIT !== 1'b0) begin failures++; $display("FAIL wr2_ack: got %b expected 0", BUSYWAIT); end
    step();
    WRITE = 1'b0; READ = 1'b1; ADDRESS = 8'h16;
    #1;
    checks++;
    if (READDATA !== 8'h5A || BUSYWAIT !== 1'b0) begin
      failures++;
      $display("FAIL wr_readback: got rd=%h bw=%b expected rd=5a bw=0", READDATA, BUSYWAIT);
    end
    step();
  endtask

  task automatic test_dirty_miss();
    int n;
    READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'hB4;
    #1;
    checks++;
    if (BUSYWAIT !== 1'b1 || READDATA !== 8'h00) begin
      failures++;
      $display("FAIL dirty_idle: got bw=%b rd=%h expected bw=1 rd=00", BUSYWAIT, READDATA);
    end
    step();
    checks++;
    if (MEM_WRITE !== 1'b1 || MEM_READ !== 1'b0 || MEM_ADDRESS !== 6'h05 || MEM_WRITEDATA !== 32'hDD5ABBAA) begin
      failures++;
      $display("FAIL writeback: got mw=%b mr=%b ma=%h mwd=%h expected mw=1 mr=0 ma=05 mwd=dd5abbaa",
               MEM_WRITE, MEM_READ, MEM_ADDRESS, MEM_WRITEDATA);
    end
    n = 0;
    while (MEM_READ !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (n !== 6 || MEM_ADDRESS !== 6'h2D || MEM_WRITE !== 1'b0) begin
      failures++;
      $display("FAIL wb_to_fetch: got n=%0d ma=%h mw=%b expected n=6 ma=2d mw=0", n, MEM_ADDRESS, MEM_WRITE);
    end
    wait_not_busy(20, n);
    checks++;
    if (n !== 6 || READDATA !== 8'h11) begin
      failures++;
      $display("FAIL dirty_fill: got n=%0d rd=%h expected n=6 rd=11", n, READDATA);
    end
    step();
  endtask

  task automatic test_write_miss();
    int n;
    READ = 1'b0; WRITE = 1'b1; ADDRESS = 8'h08; WRITEDATA = 8'h77;
    #1;
    checks++;
    if (BUSYWAIT !== 1'b1) begin failures++; $display("FAIL wmiss_idle: got %b expected 1", BUSYWAIT); end
    step();
    checks++;
    if (MEM_READ !== 1'b1 || MEM_WRITE !== 1'b0 || MEM_ADDRESS !== 6'h02) begin
      failures++;
      $display("FAIL wmiss_fetch: got mr=%b mw=%b ma=%h expected mr=1 mw=0 ma=02", MEM_READ, MEM_WRITE, MEM_ADDRESS);
    end
    wait_not_busy(20, n);
    checks++;
    if (n !== 7) begin failures++; $display("FAIL wmiss_latency: got %0d cycles expected 7", n); end
    step();
    WRITE = 1'b0; READ = 1'b1;
    #1;
    checks++;
    if (READDATA !== 8'h77) begin failures++; $display("FAIL wmiss_byte: got %h expected 77", READDATA); end
    ADDRESS = 8'h09;
    #1;
    checks++;
    if (READDATA !== 8'h0B) begin failures++; $display("FAIL wmiss_fill: got %h expected 0b", READDATA); end
    // READ and WRITE together behave as a store
    ADDRESS = 8'h0A; WRITEDATA = 8'h99; WRITE = 1'b1;
    #1;
    checks++;
    if (BUSYWAIT !== 1'b1 || READDATA !== 8'h00) begin
      failures++;
      $display("FAIL rw_as_write: got bw=%b rd=%h expected bw=1 rd=00", BUSYWAIT, READDATA);
    end
    step();
    WRITE = 1'b0;
    #1;
    checks++;
    if (READDATA !== 8'h99 || BUSYWAIT !== 1'b0) begin
      failures++;
      $display("FAIL rw_readback: got rd=%h bw=%b expected rd=99 bw=0", READDATA, BUSYWAIT);
    end
    step();
  endtask

  task automatic test_reset_mid_fetch();
    int n;
    READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h14;
    step();
    step();
    checks++;
    if (MEM_READ !== 1'b1) begin failures++; $display("FAIL rst_pre_fetch: got %b expected 1", MEM_READ); end
    #2 RESET = 1'b1;
    #1;
    checks++;
    if (MEM_READ !== 1'b0 || BUSYWAIT !== 1'b0 || MEM_ADDRESS !== 6'h00) begin
      failures++;
      $display("FAIL rst_async: got mr=%b bw=%b ma=%h expected mr=0 bw=0 ma=00", MEM_READ, BUSYWAIT, MEM_ADDRESS);
    end
    step();
    RESET = 1'b0;
    ADDRESS = 8'h08;
    #1;
    checks++;
    if (BUSYWAIT !== 1'b1 || READDATA !== 8'h00) begin
      failures++;
      $display("FAIL rst_valid_clear: got bw=%b rd=%h expected bw=1 rd=00", BUSYWAIT, READDATA);
    end
    ADDRESS = 8'h14;
    #1;
    checks++;
    if (BUSYWAIT !== 1'b1) begin failures++; $display("FAIL rst_remiss: got %b expected 1", BUSYWAIT); end
    step();
    checks++;
    if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 6'h05) begin
      failures++;
      $display("FAIL rst_refetch: got mr=%b ma=%h expected mr=1 ma=05", MEM_READ, MEM_ADDRESS);
    end
    wait_not_busy(20, n);
    checks++;
    if (n !== 6 || READDATA !== 8'hAA) begin
      failures++;
      $display("FAIL rst_refill: got n=%0d rd=%h expected n=6 rd=aa", n, READDATA);
    end
    READ = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_read_hits();
    test_back_to_back();
    test_dirty_miss();
    test_write_miss();
    test_reset_mid_fetch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
